rom_port_arbiter: RTL and testbench

- Shares the single synchronous read port of the 64x64 12-bit image ROM (4096 entries, 12-bit address {y[5:0], x[5:0]}, 1-cycle registered output) between two requesters.
- Requester 0 is the pixel/background draw path. Requester 1 is the sprite/overlay fetch path.
- Sits between the draw pipelines and the ROM instance. Drives the ROM address and returns tagged read data with a fixed latency.
- Round-robin arbitration during blanking. Strict requester-0 priority during active display, with a starvation guard for requester 1.

---
 rtl/rom_port_arbiter.sv | 102 ++++++++++
 tb/tb_rom_port_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/rom_port_arbiter.sv
// Shares the single synchronous read port of the image ROM between the draw path (0)
// and the sprite fetch path (1); returns tagged read data with fixed latency.
module rom_port_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 12,
    parameter int ROM_LAT    = 1,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              display_active,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    output logic              req1_ready,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_rgb,
    output logic              rsp0_valid,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp_rgb
);

    // Handshake: a request transfers in a cycle where valid && ready. ready is
    // combinational from the valids and registered arbiter state, never rises
    // without its valid, and at most one ready is high per cycle. Responses
    // cannot be stalled.

    logic       last_grant;   // 1 = requester 1 won the most recent grant
    logic [7:0] starve_cnt;
    logic       grant0;
    logic       grant1;
    logic [1:0] tag_q [0:ROM_LAT];  // {v0, v1} per stage

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst_n) begin
            if (req0_valid && !req1_valid) begin
                grant0 = 1'b1;
            end else if (req1_valid && !req0_valid) begin
                grant1 = 1'b1;
            end else if (req0_valid && req1_valid) begin
                if (display_active) begin
                    if (starve_cnt == 8'(STARVE_MAX)) begin
                        grant1 = 1'b1;
                    end else begin
                        grant0 = 1'b1;
                    end
                end else if (last_grant) begin
                    grant0 = 1'b1;
                end else begin
                    grant1 = 1'b1;
                end
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rom_addr   <= '0;
            last_grant <= 1'b1;
            starve_cnt <= 8'd0;
            for (int i = 0; i <= ROM_LAT; i++) begin
                tag_q[i] <= 2'b00;
            end
        end else begin
            if (grant0) begin
                rom_addr <= req0_addr;
            end else if (grant1) begin
                rom_addr <= req1_addr;
            end

            if (grant0 || grant1) begin
                last_grant <= grant1;
            end

            // Requester 1 only accrues starvation while it is being denied in active video.
            if (display_active && req1_valid && !grant1) begin
                if (starve_cnt != 8'(STARVE_MAX)) begin
                    starve_cnt <= starve_cnt + 8'd1;
                end
            end else begin
                starve_cnt <= 8'd0;
            end

            tag_q[0] <= {grant0, grant1};
            for (int i = 1; i <= ROM_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign rsp0_valid = tag_q[ROM_LAT][1];
    assign rsp1_valid = tag_q[ROM_LAT][0];
    assign rsp_rgb    = rom_rgb;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter: instance a (ROM_LAT=1, STARVE_MAX=4) and
// instance b (ROM_LAT=3) each driven against a behavioural ROM model.
module tb_rom_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        display_active;

    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [11:0] req0_addr, req1_addr, rom_addr, rom_rgb, rsp_rgb;
    logic        rsp0_valid, rsp1_valid;

    logic        b_req0_valid, b_req1_valid, b_req0_ready, b_req1_ready;
    logic [11:0] b_req0_addr, b_req1_addr, b_rom_addr, b_rom_rgb, b_rsp_rgb;
    logic        b_rsp0_valid, b_rsp1_valid;

    logic [11:0] a_rom_q;
    logic [11:0] b_rom_q [0:2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rom_port_arbiter #(.ADDR_W(12), .DATA_W(12), .ROM_LAT(1), .STARVE_MAX(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .display_active(display_active),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
        .rom_addr(rom_addr), .rom_rgb(rom_rgb),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_rgb(rsp_rgb)
    );

    rom_port_arbiter #(.ADDR_W(12), .DATA_W(12), .ROM_LAT(3), .STARVE_MAX(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .display_active(display_active),
        .req0_valid(b_req0_valid), .req0_addr(b_req0_addr), .req0_ready(b_req0_ready),
        .req1_valid(b_req1_valid), .req1_addr(b_req1_addr), .req1_ready(b_req1_ready),
        .rom_addr(b_rom_addr), .rom_rgb(b_rom_rgb),
        .rsp0_valid(b_rsp0_valid), .rsp1_valid(b_rsp1_valid), .rsp_rgb(b_rsp_rgb)
    );

    // ROM contents: an arbitrary but easily recomputed pattern.
    function automatic logic [11:0] rom_fn(input logic [11:0] a);
        return (a * 12'd7) + 12'h035;
    endfunction

    always_ff @(posedge clk) begin
        a_rom_q    <= rom_fn(rom_addr);
        b_rom_q[0] <= rom_fn(b_rom_addr);
        b_rom_q[1] <= b_rom_q[0];
        b_rom_q[2] <= b_rom_q[1];
    end
    assign rom_rgb   = a_rom_q;
    assign b_rom_rgb = b_rom_q[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle on instance a: inputs change just after the edge, checks follow at +2.
    task automatic cyc_a(input logic v0, input logic [11:0] a0, input logic v1, input logic [11:0] a1);
        @(posedge clk);
        #1;
        req0_valid = v0; req0_addr = a0;
        req1_valid = v1; req1_addr = a1;
        #1;
    endtask

    task automatic cyc_b(input logic v0, input logic [11:0] a0);
        @(posedge clk);
        #1;
        b_req0_valid = v0; b_req0_addr = a0;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) cyc_a(1'b1, 12'h001, 1'b1, 12'h002);
        chk("rst_ready0", req0_ready, 1'b0);
        chk("rst_ready1", req1_ready, 1'b0);
        chk("rst_rom_addr", rom_addr, 12'h000);
        chk("rst_rsp0", rsp0_valid, 1'b0);
        chk("rst_rsp1", rsp1_valid, 1'b0);
        chk("rst_b_rom_addr", b_rom_addr, 12'h000);
        chk("rst_b_rsp0", b_rsp0_valid, 1'b0);
        rst_n = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        b_req0_valid = 1'b0;
    endtask

    task automatic single_read();
        cyc_a(1'b1, 12'h041, 1'b0, 12'h000);
        chk("sr_ready0", req0_ready, 1'b1);
        chk("sr_ready1", req1_ready, 1'b0);
        cyc_a(1'b0, 12'h000, 1'b0, 12'h000);
        chk("sr_rom_addr", rom_addr, 12'h041);
        chk("sr_rsp0_early", rsp0_valid, 1'b0);
        cyc_a(1'b0, 12'h000, 1'b0, 12'h000);
        chk("sr_rsp0", rsp0_valid, 1'b1);
        chk("sr_rsp1", rsp1_valid, 1'b0);
        chk("sr_rgb", rsp_rgb, rom_fn(12'h041));
        cyc_a(1'b0, 12'h000, 1'b0, 12'h000);
        chk("sr_rsp0_after", rsp0_valid, 1'b0);
        chk("sr_rsp1_after", rsp1_valid, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        display_active = 1'b1;
        req0_valid = 1'b0; req0_addr = '0; req1_valid = 1'b0; req1_addr = '0;
        b_req0_valid = 1'b0; b_req0_addr = '0; b_req1_valid = 1'b0; b_req1_addr = '0;

        do_reset();
        single_read();

        // Round-robin in blanking, starting from reset: grants 0,1,0,1,0,1.
        do_reset();
        display_active = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i < 6) cyc_a(1'b1, 12'h010, 1'b1, 12'h020);
            else       cyc_a(1'b0, 12'h000, 1'b0, 12'h000);
            if (i < 6) begin
                chk($sformatf("rr_ready0_%0d", i), req0_ready, ((i % 2) == 0));
                chk($sformatf("rr_ready1_%0d", i), req1_ready, ((i % 2) == 1));
            end
            if (i >= 2) begin
                chk($sformatf("rr_rsp0_%0d", i), rsp0_valid, (((i - 2) % 2) == 0));
                chk($sformatf("rr_rsp1_%0d", i), rsp1_valid, (((i - 2) % 2) == 1));
                chk($sformatf("rr_rgb_%0d", i), rsp_rgb,
                    (((i - 2) % 2) == 1) ? rom_fn(12'h020) : rom_fn(12'h010));
            end else begin
                chk($sformatf("rr_rsp_idle_%0d", i), {rsp0_valid, rsp1_valid}, 2'b00);
            end
        end

        // Active display with STARVE_MAX=4: requester 1 forced in every 5th cycle.
        // Addresses move every cycle, so data shows which address was sampled.
        display_active = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            if (k <= 20) cyc_a(1'b1, 12'h030 + 12'(k), 1'b1, 12'h040 + 12'(k));
            else         cyc_a(1'b0, 12'h000, 1'b0, 12'h000);
            if (k <= 20) begin
                chk($sformatf("st_ready0_%0d", k), req0_ready, ((k % 5) != 0));
                chk($sformatf("st_ready1_%0d", k), req1_ready, ((k % 5) == 0));
            end
            if (k >= 3) begin
                chk($sformatf("st_rsp0_%0d", k), rsp0_valid, (((k - 2) % 5) != 0));
                chk($sformatf("st_rsp1_%0d", k), rsp1_valid, (((k - 2) % 5) == 0));
                chk($sformatf("st_rgb_%0d", k), rsp_rgb,
                    (((k - 2) % 5) == 0) ? rom_fn(12'h040 + 12'(k - 2)) : rom_fn(12'h030 + 12'(k - 2)));
            end
        end

        // Idle hold: one accept, then nothing; rom_addr must hold.
        for (int i = 0; i < 7; i++) begin
            if (i == 0) cyc_a(1'b1, 12'h0FF, 1'b0, 12'h000);
            else        cyc_a(1'b0, 12'h000, 1'b0, 12'h000);
            if (i == 0) chk("ih_ready0", req0_ready, 1'b1);
            else        chk($sformatf("ih_rom_addr_%0d", i), rom_addr, 12'h0FF);
            chk($sformatf("ih_rsp0_%0d", i), rsp0_valid, (i == 2));
            chk($sformatf("ih_rsp1_%0d", i), rsp1_valid, 1'b0);
            if (i == 2) chk("ih_rgb", rsp_rgb, rom_fn(12'h0FF));
        end

        // Reset while a requester-1 read is in flight: its response is dropped.
        display_active = 1'b0;
        cyc_a(1'b0, 12'h000, 1'b1, 12'h123);
        chk("mf_ready1", req1_ready, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        chk("mf_rst_ready0", req0_ready, 1'b0);
        chk("mf_rst_ready1", req1_ready, 1'b0);
        chk("mf_rst_rsp1", rsp1_valid, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        chk("mf_rom_addr", rom_addr, 12'h000);
        chk("mf_rsp0", rsp0_valid, 1'b0);
        chk("mf_rsp1", rsp1_valid, 1'b0);
        for (int i = 0; i < 2; i++) begin
            cyc_a(1'b0, 12'h000, 1'b0, 12'h000);
            chk($sformatf("mf_rsp1_late_%0d", i), rsp1_valid, 1'b0);
        end
        display_active = 1'b1;
        single_read();

        // First blanking tie after a reset goes to requester 0 (last_grant reset to 1).
        do_reset();
        display_active = 1'b0;
        cyc_a(1'b1, 12'h055, 1'b1, 12'h066);
        chk("tie_ready0", req0_ready, 1'b1);
        chk("tie_ready1", req1_ready, 1'b0);
        cyc_a(1'b0, 12'h000, 1'b0, 12'h000);
        chk("tie_rom_addr", rom_addr, 12'h055);

        // ROM_LAT=3: back-to-back reads of 0..7, responses 4 cycles after each accept.
        for (int j = 0; j < 13; j++) begin
            cyc_b((j < 8), 12'(j));
            chk($sformatf("lat3_ready0_%0d", j), b_req0_ready, (j < 8));
            chk($sformatf("lat3_rsp1_%0d", j), b_rsp1_valid, 1'b0);
            if (j >= 4 && j < 12) begin
                chk($sformatf("lat3_rsp0_%0d", j), b_rsp0_valid, 1'b1);
                chk($sformatf("lat3_rgb_%0d", j), b_rsp_rgb, rom_fn(12'(j - 4)));
            end else begin
                chk($sformatf("lat3_rsp0_%0d", j), b_rsp0_valid, 1'b0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
